// File: rtl/axi_burst_len_planner_if.sv
// axi_burst_len_planner_if: bundles the video-size inputs, the burst-command handshake and the status flags of the planner.
//   master modport : the planner (samples vactive/hactive/fsync/cmd_ready, drives cmd_*/busy/frame_done)
//   slave modport  : the AXI read master / frame controller on the other side
//   BURST_PLAN_ADDR_EN adds base_addr, line_stride (in) and cmd_addr (out), plus the ASIZE parameter.
interface axi_burst_len_planner_if #(
    parameter int LSIZE = 9
`ifdef BURST_PLAN_ADDR_EN
    ,
    parameter int ASIZE = 32
`endif
);
    logic [15:0]      vactive;
    logic [15:0]      hactive;
    logic             fsync;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LSIZE-1:0] cmd_len;
    logic             cmd_line_last;
    logic             cmd_frame_last;
    logic             busy;
    logic             frame_done;
`ifdef BURST_PLAN_ADDR_EN
    logic [ASIZE-1:0] base_addr;
    logic [ASIZE-1:0] line_stride;
    logic [ASIZE-1:0] cmd_addr;
`endif

    modport master (
        input  vactive, hactive, fsync, cmd_ready,
`ifdef BURST_PLAN_ADDR_EN
        input  base_addr, line_stride,
        output cmd_addr,
`endif
        output cmd_valid, cmd_len, cmd_line_last, cmd_frame_last, busy, frame_done
    );

    modport slave (
        output vactive, hactive, fsync, cmd_ready,
`ifdef BURST_PLAN_ADDR_EN
        output base_addr, line_stride,
        input  cmd_addr,
`endif
        input  cmd_valid, cmd_len, cmd_line_last, cmd_frame_last, busy, frame_done
    );
endinterface

// File: rtl/axi_burst_len_planner.sv
// axi_burst_len_planner: turns the active video size into a stream of AXI burst-length commands with line/frame-last tags.
//   clock : system clock
//   rst_n : asynchronous active-low reset
//   bus   : axi_burst_len_planner_if.master (vactive/hactive/fsync in, cmd_valid/cmd_ready handshake,
//           cmd_len/cmd_line_last/cmd_frame_last, busy, frame_done)
//   Define BURST_PLAN_ADDR_EN to add per-command start addresses (base_addr, line_stride, cmd_addr).
module axi_burst_len_planner #(
    parameter int BURST_LEN = 200,
    parameter     MODE      = "ONCE",
    parameter int AXI_DSIZE = 256,
    parameter int DSIZE     = 24,
    parameter int LSIZE     = 9
`ifdef BURST_PLAN_ADDR_EN
    ,
    parameter int ASIZE     = 32
`endif
) (
    input logic                      clock,
    input logic                      rst_n,
    axi_burst_len_planner_if.master  bus
);
    localparam bit          LINE_M = (MODE == "LINE");
    localparam int          SH     = $clog2(AXI_DSIZE);
    localparam logic [31:0] BL32   = BURST_LEN;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

    state_t           state_q;
    logic [1:0]       step_q;
    logic [15:0]      h_q, v_q, ph_q, pv_q, line_q, line_d;
    logic [47:0]      bits_q;
    logic [31:0]      beats_q, ncmd_q, burst_q, burst_d, rem;
    logic [LSIZE-1:0] last_len_q, len_q, len_d;
    logic             pend_q, valid_q, ll_q, fl_q, busy_q, done_q;
    logic             start, hs, restart, calc_go, empty, load, ll_d, fl_d;

    assign rem = beats_q % BL32;

    always_comb begin
        start   = bus.fsync && state_q != ISSUE;
        hs      = state_q == ISSUE && valid_q && bus.cmd_ready;
        // a pending or coincident fsync abandons the frame once the shown command is taken
        restart = hs && (bus.fsync || pend_q);
        calc_go = state_q == CALC && step_q == 2'd3 && !bus.fsync;
        empty   = beats_q == '0 || v_q == '0;
        load    = (calc_go && !empty) || (hs && !restart && !fl_q);
        burst_d = (state_q != ISSUE || ll_q) ? '0 : burst_q + 32'd1;
        line_d  = state_q != ISSUE ? '0 : ll_q ? line_q + 16'd1 : line_q;
        ll_d    = burst_d == ncmd_q - 32'd1;
        fl_d    = ll_d && (!LINE_M || line_d == v_q - 16'd1);
        len_d   = ll_d ? last_len_q : LSIZE'(BURST_LEN);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            h_q        <= '0;
            v_q        <= '0;
            ph_q       <= '0;
            pv_q       <= '0;
            line_q     <= '0;
            bits_q     <= '0;
            beats_q    <= '0;
            ncmd_q     <= '0;
            burst_q    <= '0;
            last_len_q <= '0;
            len_q      <= '0;
            pend_q     <= 1'b0;
            valid_q    <= 1'b0;
            ll_q       <= 1'b0;
            fl_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // free-running pipeline; only read by the CALC decision three cycles after h_q/v_q load
            bits_q     <= LINE_M ? 48'(h_q) * 48'(DSIZE) : 48'(h_q) * 48'(v_q) * 48'(DSIZE);
            beats_q    <= 32'(bits_q >> SH) + {31'b0, |bits_q[SH-1:0]};
            ncmd_q     <= beats_q / BL32 + {31'b0, rem != '0};
            last_len_q <= rem != '0 ? LSIZE'(rem) : LSIZE'(BURST_LEN);
            done_q     <= 1'b0;
            step_q     <= step_q + 2'd1;
            if (state_q == DONE)
                state_q <= IDLE;
            if (bus.fsync && state_q == ISSUE) begin
                pend_q <= 1'b1;
                ph_q   <= bus.hactive;
                pv_q   <= bus.vactive;
            end
            if (calc_go) begin
                state_q <= empty ? DONE : ISSUE;
                busy_q  <= !empty;
                done_q  <= empty;
            end
            if (load) begin
                valid_q <= 1'b1;
                len_q   <= len_d;
                ll_q    <= ll_d;
                fl_q    <= fl_d;
                burst_q <= burst_d;
                line_q  <= line_d;
            end
            if (hs && fl_q)
                done_q <= 1'b1;
            if (hs && (fl_q || restart))
                valid_q <= 1'b0;
            if (hs && fl_q && !restart) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
            end
            if (start || restart) begin
                state_q <= CALC;
                step_q  <= '0;
                busy_q  <= 1'b1;
                pend_q  <= 1'b0;
                h_q     <= bus.fsync ? bus.hactive : ph_q;
                v_q     <= bus.fsync ? bus.vactive : pv_q;
            end
        end
    end

    assign bus.cmd_valid      = valid_q;
    assign bus.cmd_len        = len_q;
    assign bus.cmd_line_last  = ll_q;
    assign bus.cmd_frame_last = fl_q;
    assign bus.busy           = busy_q;
    assign bus.frame_done     = done_q;

`ifdef BURST_PLAN_ADDR_EN
    localparam logic [ASIZE-1:0] ASTEP = ASIZE'(BURST_LEN * AXI_DSIZE / 8);

    logic [ASIZE-1:0] base_q, pbase_q, lbase_q, addr_q, lbase_d, addr_d;

    always_comb begin
        lbase_d = state_q != ISSUE ? base_q : ll_q ? lbase_q + bus.line_stride : lbase_q;
        addr_d  = (state_q != ISSUE || ll_q) ? lbase_d : addr_q + ASTEP;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            pbase_q <= '0;
            lbase_q <= '0;
            addr_q  <= '0;
        end else begin
            if (bus.fsync && state_q == ISSUE)
                pbase_q <= bus.base_addr;
            if (start || restart)
                base_q <= bus.fsync ? bus.base_addr : pbase_q;
            if (load) begin
                lbase_q <= lbase_d;
                addr_q  <= addr_d;
            end
        end
    end

    assign bus.cmd_addr = addr_q;
`endif
endmodule

// File: tb/tb_axi_burst_len_planner.sv
// tb_axi_burst_len_planner: checks a LINE-mode and a ONCE-mode planner against a queue of expected commands.
module tb_axi_burst_len_planner;
    localparam int BL = 200, DSIZE = 24, AXI_DSIZE = 256;

    logic        clock = 1'b0, rst_n = 1'b0, fsync = 1'b0, ready = 1'b0, sel = 1'b0;
    logic [15:0] h = '0, v = '0;
    int          checks = 0, errors = 0;
    logic [10:0] exp_q[$];

    always #5 clock = ~clock;

    axi_burst_len_planner_if bl ();
    axi_burst_len_planner_if bo ();

    assign bl.hactive   = h;
    assign bl.vactive   = v;
    assign bl.cmd_ready = ready;
    assign bl.fsync     = fsync & ~sel;
    assign bo.hactive   = h;
    assign bo.vactive   = v;
    assign bo.cmd_ready = ready;
    assign bo.fsync     = fsync & sel;
`ifdef BURST_PLAN_ADDR_EN
    assign bl.base_addr   = '0;
    assign bl.line_stride = '0;
    assign bo.base_addr   = '0;
    assign bo.line_stride = '0;
`endif

    axi_burst_len_planner #(.MODE("LINE")) dut_l (.clock(clock), .rst_n(rst_n), .bus(bl.master));
    axi_burst_len_planner #(.MODE("ONCE")) dut_o (.clock(clock), .rst_n(rst_n), .bus(bo.master));

    logic        o_valid, o_busy, o_done;
    logic [10:0] o_cmd;
    logic [27:0] all_out;
    assign o_valid = sel ? bo.cmd_valid : bl.cmd_valid;
    assign o_busy  = sel ? bo.busy : bl.busy;
    assign o_done  = sel ? bo.frame_done : bl.frame_done;
    assign o_cmd   = sel ? {bo.cmd_len, bo.cmd_line_last, bo.cmd_frame_last}
                         : {bl.cmd_len, bl.cmd_line_last, bl.cmd_frame_last};
    assign all_out = {bl.cmd_valid, bl.cmd_len, bl.cmd_line_last, bl.cmd_frame_last, bl.busy, bl.frame_done,
                      bo.cmd_valid, bo.cmd_len, bo.cmd_line_last, bo.cmd_frame_last, bo.busy, bo.frame_done};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected commands: each transfer is carved into chunks of at most BL beats
    task automatic plan(input bit once, input int hh, input int vv);
        longint bits, beats;
        int     n;
        exp_q.delete();
        bits  = once ? longint'(hh) * vv * DSIZE : longint'(hh) * DSIZE;
        beats = (bits + AXI_DSIZE - 1) / AXI_DSIZE;
        n     = once ? 1 : vv;
        for (int l = 0; l < n; l++)
            for (longint b = beats; b > 0; b -= BL)
                exp_q.push_back({9'(b > BL ? BL : b), 1'(b <= BL), 1'(b <= BL && l == n - 1)});
    endtask

    task automatic start(input bit s, input int hh, input int vv);
        @(negedge clock);
        sel   = s;
        h     = 16'(hh);
        v     = 16'(vv);
        fsync = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            fsync = 1'b0;
            chk("calc_window", {o_valid, o_busy, o_done}, 3'b010);
        end
    endtask

    task automatic drain(input int pct);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 5000) begin
            @(negedge clock);
            guard++;
            chk("cmd", {o_valid, o_cmd}, {1'b1, exp_q[0]});
            ready = $urandom_range(99) < pct;
            if (ready)
                void'(exp_q.pop_front());
        end
        chk("drain_left", exp_q.size(), 0);
        @(negedge clock);
        ready = 1'b0;
        chk("frame_done", {o_valid, o_busy, o_done}, 3'b001);
        @(negedge clock);
        chk("done_pulse", o_done, 0);
    endtask

    task automatic frame(input bit s, input int hh, input int vv, input int pct);
        plan(s, hh, vv);
        start(s, hh, vv);
        drain(pct);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        int hh, vv;
        #1 chk("reset_outputs", all_out, 0);
        #20;
        @(negedge clock);
        rst_n = 1'b1;
        frame(0, 1920, 2, 100);
        frame(1, 1920, 1080, 100);
        frame(0, 100, 1, 100);
        frame(0, 9000, 3, 50);
        frame(0, 0, 4, 100);
        frame(1, 0, 5, 100);
        frame(0, 100, 0, 100);
        // fsync while a command is stalled: held, taken, then restart with the new size
        start(0, 9000, 2);
        @(negedge clock);
        chk("abort_first", {o_valid, o_cmd}, {1'b1, 9'd200, 2'b00});
        ready = 1'b0;
        @(negedge clock);
        fsync = 1'b1;
        h     = 16'd1920;
        v     = 16'd1;
        repeat (2) begin
            @(negedge clock);
            fsync = 1'b0;
            chk("abort_hold", {o_valid, o_cmd}, {1'b1, 9'd200, 2'b00});
        end
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            ready = 1'b0;
            chk("abort_calc", {o_valid, o_busy, o_done}, 3'b010);
        end
        plan(0, 1920, 1);
        drain(100);
        for (int i = 0; i < 8; i++) begin
            s  = 1'($urandom_range(1));
            hh = int'($urandom_range(4000));
            vv = int'($urandom_range(3));
            frame(s, hh, vv, int'($urandom_range(30, 100)));
        end
        // asynchronous reset in the middle of a frame
        start(1, 1920, 1080);
        ready = 1'b1;
        repeat (10) @(negedge clock);
        chk("pre_reset_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_issue", all_out, 0);
        @(negedge clock);
        ready = 1'b0;
        rst_n = 1'b1;
        frame(0, 1920, 2, 70);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
